// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I word type, BTB update entry and BTB index width.
package rv32i_types;
    typedef logic [31:0] rv32i_word;
    typedef struct packed {
        rv32i_word pc;
        rv32i_word target;
    } btb_upd_t;
    localparam int BTB_BIT_ENTRY = 5;
endpackage

// File: rtl/btb_update_buffer.sv
// btb_update_buffer: coalescing FIFO of taken-branch updates draining into the BTB write port.
module btb_update_buffer
    import rv32i_types::*;
#(
    parameter int depth     = 4,
    parameter int bit_entry = BTB_BIT_ENTRY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    input  logic                     ex_taken,
    input  logic [31:0]              ex_pc,
    input  logic [31:0]              ex_target,
    input  logic [31:0]              fetch_pc,
    output logic [31:0]              w_pc,
    output logic [31:0]              target_in,
    output logic                     load,
    output logic                     full,
    output logic [$clog2(depth):0]   count
);
    localparam int pw = $clog2(depth);
    localparam int cw = pw + 1;

    btb_upd_t         entries [depth];
    logic [pw-1:0]    head, tail;
    logic [cw-1:0]    cnt;
    logic [depth-1:0] match;
    logic             accept, pop, coalesce, push;

    assign full      = cnt == cw'(depth);
    assign count     = cnt;
    assign w_pc      = entries[head].pc;
    assign target_in = entries[head].target;
    // A full buffer drains even when the head collides with the fetch read index.
    assign pop       = (cnt != '0) && ((entries[head].pc[bit_entry+1:2] != fetch_pc[bit_entry+1:2]) || full);
    assign load      = pop;
    assign accept    = ex_valid && ex_taken;

    // An entry is occupied when its distance from head is below count; the popping head is excluded.
    always_comb begin
        match = '0;
        for (int i = 0; i < depth; i++)
            match[i] = (cw'(pw'(pw'(i) - head)) < cnt) && (entries[i].pc == ex_pc) && !(pop && (pw'(i) == head));
    end

    assign coalesce = accept && (match != '0);
    assign push     = accept && !coalesce && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (pop) head <= head + pw'(1);
            if (push) tail <= tail + pw'(1);
            cnt <= cnt + cw'(push) - cw'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < depth; i++)
            if (coalesce && match[i]) entries[i].target <= ex_target;
        if (push) entries[tail] <= '{pc: ex_pc, target: ex_target};
    end
endmodule
